// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU UART host: FSM states, response status codes,
// length limits and the request-length clamp helpers.
package tpu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSendCmd,
    StSendPayload,
    StWaitResp,
    StRespOut
  } host_state_e;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_TIMEOUT   = 2'b01;
  localparam logic [1:0] ST_FRAME_ERR = 2'b10;

  localparam logic [3:0] MAX_PAYLOAD_LEN = 4'd8;
  localparam logic [2:0] MAX_RESP_LEN    = 3'd4;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > MAX_PAYLOAD_LEN) ? MAX_PAYLOAD_LEN : len;
  endfunction

  function automatic logic [2:0] clamp_resp_len(input logic [2:0] len);
    return (len > MAX_RESP_LEN) ? MAX_RESP_LEN : len;
  endfunction

endpackage

// File: rtl/uart_host_phy.sv
// 8N1 UART PHY: TX serializer and RX synchronizer/deserializer with a byte-level interface.
// rx_start (confirmed start bit) exists only when TPU_UART_HOST_TIMEOUT_EN is defined.
module uart_host_phy #(
  parameter int unsigned BIT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_frame_err
`ifdef TPU_UART_HOST_TIMEOUT_EN
  ,
  output logic       rx_start
`endif
);

  localparam int unsigned CntW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'((BIT_CYC > 0) ? BIT_CYC - 1 : 0);
  localparam logic [CntW-1:0] HalfLast = CntW'((BIT_CYC / 2 > 0) ? BIT_CYC / 2 - 1 : 0);

  // ---------------- TX ----------------
  logic            tx_active_q;
  logic [3:0]      tx_bit_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [8:0]      tx_shift_q;
  logic            tx_q;
  logic            tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BitLast);
  // Ready during the final stop-bit cycle so the next frame starts with no idle gap.
  assign tx_ready   = !tx_active_q || (tx_bit_q == 4'd9 && tx_bit_end);
  assign uart_tx    = tx_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_active_q <= 1'b0;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      tx_shift_q  <= '1;
      tx_q        <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_active_q <= 1'b1;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      tx_shift_q  <= {1'b1, tx_data};
      tx_q        <= 1'b0;
    end else if (tx_active_q) begin
      if (tx_bit_end) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_active_q <= 1'b0;
          tx_q        <= 1'b1;
        end else begin
          tx_bit_q   <= tx_bit_q + 4'd1;
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  // ---------------- RX ----------------
  logic            sync1_q, sync2_q, prev_q;
  logic            rx_active_q;
  logic [3:0]      rx_bit_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [7:0]      rx_shift_q;
  logic            rx_done_q;
  logic            rx_err_q;
`ifdef TPU_UART_HOST_TIMEOUT_EN
  logic            rx_start_q;
  assign rx_start = rx_start_q;
`endif

  // A completed byte is offered for one cycle only; if not accepted it is dropped.
  assign rx_valid     = rx_done_q && rx_ready;
  assign rx_data      = rx_shift_q;
  assign rx_frame_err = rx_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      rx_active_q <= 1'b0;
      rx_bit_q    <= '0;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      rx_done_q   <= 1'b0;
      rx_err_q    <= 1'b0;
`ifdef TPU_UART_HOST_TIMEOUT_EN
      rx_start_q  <= 1'b0;
`endif
    end else begin
      sync1_q   <= uart_rx;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      rx_done_q <= 1'b0;
`ifdef TPU_UART_HOST_TIMEOUT_EN
      rx_start_q <= 1'b0;
`endif
      if (!rx_active_q) begin
        if (prev_q && !sync2_q) begin
          rx_active_q <= 1'b1;
          rx_cnt_q    <= '0;
          rx_bit_q    <= '0;
        end
      end else if (rx_bit_q == 4'd0) begin
        // Confirm the start bit at half a bit period; glitches return to idle.
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_q <= '0;
          if (!sync2_q) begin
            rx_bit_q <= 4'd1;
`ifdef TPU_UART_HOST_TIMEOUT_EN
            rx_start_q <= 1'b1;
`endif
          end else begin
            rx_active_q <= 1'b0;
          end
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
      end else begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_q <= '0;
          if (rx_bit_q == 4'd9) begin
            rx_active_q <= 1'b0;
            rx_done_q   <= 1'b1;
            rx_err_q    <= !sync2_q;
          end else begin
            rx_shift_q <= {sync2_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tpu_uart_host.sv
// Host-side UART command engine: sends a command byte plus payload, then collects a response.
// Define TPU_UART_HOST_TIMEOUT_EN to build the response watchdog (status 01).
module tpu_uart_host
  import tpu_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ     = 100_000_000,
  parameter int unsigned BAUD_RATE      = 115200,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [63:0] req_payload,
  input  logic [3:0]  req_len,
  input  logic [2:0]  req_resp_len,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic        busy
);

  localparam int unsigned BIT_CYC = CLOCK_FREQ / BAUD_RATE;

  host_state_e state_q, state_d;
  logic [63:0] payload_q, payload_d;
  logic [3:0]  len_q, len_d;
  logic [2:0]  resp_len_q, resp_len_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  rx_cnt_q, rx_cnt_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_status_q, rsp_status_d;

  logic       tx_valid, tx_ready, phy_tx;
  logic [7:0] tx_data;
  logic       rx_valid, rx_ready, rx_frame_err;
  logic [7:0] rx_data;
`ifdef TPU_UART_HOST_TIMEOUT_EN
  logic        rx_start;
  logic [31:0] wd_q, wd_d;
`endif

  uart_host_phy #(
    .BIT_CYC (BIT_CYC)
  ) u_phy (
    .clk          (clk),
    .rst          (rst),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .uart_tx      (phy_tx),
    .uart_rx      (uart_rx),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err)
`ifdef TPU_UART_HOST_TIMEOUT_EN
    ,
    .rx_start     (rx_start)
`endif
  );

  // Line and ready are forced while reset is held, not just after the first reset edge.
  assign uart_tx    = phy_tx | ~rst;
  assign req_ready  = rst && (state_q == StIdle);
  assign rsp_valid  = (state_q == StRespOut);
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign busy       = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    payload_d    = payload_q;
    len_d        = len_q;
    resp_len_d   = resp_len_q;
    idx_d        = idx_q;
    rx_cnt_d     = rx_cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    tx_valid     = 1'b0;
    tx_data      = req_cmd;
    rx_ready     = 1'b0;
`ifdef TPU_UART_HOST_TIMEOUT_EN
    wd_d         = wd_q;
`endif

    unique case (state_q)
      StIdle: begin
        tx_valid = req_valid && req_ready;
        if (req_valid && req_ready) begin
          payload_d    = req_payload;
          len_d        = clamp_len(req_len);
          resp_len_d   = clamp_resp_len(req_resp_len);
          idx_d        = '0;
          rsp_data_d   = '0;
          rsp_status_d = ST_OK;
          state_d      = StSendCmd;
        end
      end

      // idx_q counts payload bytes already handed to the PHY.
      StSendCmd, StSendPayload: begin
        tx_data = payload_q[{idx_q[2:0], 3'b000} +: 8];
        if (tx_ready) begin
          if (idx_q < len_q) begin
            tx_valid = 1'b1;
            idx_d    = idx_q + 4'd1;
            state_d  = StSendPayload;
          end else if (resp_len_q == 3'd0) begin
            state_d = StRespOut;
          end else begin
            rx_cnt_d = '0;
            state_d  = StWaitResp;
`ifdef TPU_UART_HOST_TIMEOUT_EN
            wd_d     = '0;
`endif
          end
        end
      end

      StWaitResp: begin
        rx_ready = 1'b1;
`ifdef TPU_UART_HOST_TIMEOUT_EN
        wd_d = rx_start ? 32'd0 : wd_q + 32'd1;
`endif
        if (rx_valid) begin
          rsp_data_d[{rx_cnt_q[1:0], 3'b000} +: 8] = rx_data;
          if (rx_frame_err) begin
            rsp_status_d = ST_FRAME_ERR;
            state_d      = StRespOut;
          end else if (rx_cnt_q + 3'd1 == resp_len_q) begin
            state_d = StRespOut;
          end else begin
            rx_cnt_d = rx_cnt_q + 3'd1;
          end
        end
`ifdef TPU_UART_HOST_TIMEOUT_EN
        if (state_d == StWaitResp && !rx_start && wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
          rsp_status_d = ST_TIMEOUT;
          state_d      = StRespOut;
        end
`endif
      end

      StRespOut: begin
        if (rsp_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      payload_q    <= '0;
      len_q        <= '0;
      resp_len_q   <= '0;
      idx_q        <= '0;
      rx_cnt_q     <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
`ifdef TPU_UART_HOST_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      payload_q    <= payload_d;
      len_q        <= len_d;
      resp_len_q   <= resp_len_d;
      idx_q        <= idx_d;
      rx_cnt_q     <= rx_cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
`ifdef TPU_UART_HOST_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_tpu_uart_host.sv
// Directed, table-driven bench for tpu_uart_host at BIT_CYC=16 with a UART reply model.
module tb_tpu_uart_host;

  localparam int BIT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [7:0]  req_cmd;
  logic [63:0] req_payload;
  logic [3:0]  req_len;
  logic [2:0]  req_resp_len;
  logic        uart_tx, uart_rx;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  tpu_uart_host #(
    .CLOCK_FREQ     (16),
    .BAUD_RATE      (1),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_payload  (req_payload),
    .req_len      (req_len),
    .req_resp_len (req_resp_len),
    .uart_tx      (uart_tx),
    .uart_rx      (uart_rx),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_status   (rsp_status),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [63:0] payload;
    logic [2:0]  resp_len;
    int          nrx;
    logic [31:0] rx;
    int          bad_stop;
    int          frames;
    logic [31:0] exp_data;
    logic [1:0]  exp_status;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic decode_frame(output logic [7:0] b, output logic ok);
    int n = 0;
    ok = 1'b1;
    b  = '0;
    while (uart_tx !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      ok = 1'b0;
    end else begin
      repeat (7) tick();
      if (uart_tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) tick();
        b[i] = uart_tx;
      end
      repeat (BIT) tick();
      if (uart_tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BIT) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) tick();
    end
    uart_rx = stop;
    repeat (BIT) tick();
    uart_rx = 1'b1;
  endtask

  task automatic wait_rsp(input int limit, output logic ok);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    ok = (rsp_valid === 1'b1);
  endtask

  task automatic issue(input logic [7:0] cmd, input logic [3:0] len, input logic [63:0] pl,
                       input logic [2:0] rl);
    req_cmd      = cmd;
    req_len      = len;
    req_payload  = pl;
    req_resp_len = rl;
    req_valid    = 1'b1;
    tick();
    req_valid    = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0] b, exp_b;
    logic       ok;
    int         t0, t1;
    issue(v.cmd, v.len, v.payload, v.resp_len);
    check($sformatf("v%0d_start_bit_after_capture", id), uart_tx, 1'b0);
    check($sformatf("v%0d_busy", id), busy, 1'b1);
    t0 = cyc;
    for (int f = 0; f < v.frames; f++) begin
      exp_b = (f == 0) ? v.cmd : v.payload[8*(f-1) +: 8];
      decode_frame(b, ok);
      check($sformatf("v%0d_frame%0d_ok", id, f), ok, 1'b1);
      check($sformatf("v%0d_frame%0d_byte", id, f), b, exp_b);
    end
    if (v.nrx > 0) begin
      repeat (20) tick();
      for (int i = 0; i < v.nrx; i++) send_byte(v.rx[8*i +: 8], (i != v.bad_stop));
    end
    wait_rsp(3000, ok);
    t1 = cyc;
    check($sformatf("v%0d_rsp_valid", id), ok, 1'b1);
    if (v.resp_len == 3'd0)
      check($sformatf("v%0d_tx_cycles", id), t1 - t0, v.frames * 10 * BIT);
    check($sformatf("v%0d_rsp_data", id), rsp_data, v.exp_data);
    check($sformatf("v%0d_rsp_status", id), rsp_status, v.exp_status);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check($sformatf("v%0d_idle_after_handshake", id), {rsp_valid, busy, req_ready}, 3'b001);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic        ok, stable, tx_idle, rdy_low;
    logic [31:0] snap;
    int          n, ts;

    //         cmd    len    payload                 rl    nrx rx            bad fr exp_data      st
    vecs[0] = '{8'h01, 4'd2, 64'hBBAA,              3'd0, 0, 32'h0,        -1, 3, 32'h0,        2'b00};
    vecs[1] = '{8'h05, 4'd0, 64'h0,                 3'd4, 4, 32'h44332211, -1, 1, 32'h44332211, 2'b00};
    vecs[2] = '{8'h09, 4'd0, 64'h0,                 3'd2, 1, 32'h7E,        0, 1, 32'h0000007E, 2'b10};
    // len 12 clamps to 8 frames of payload, resp_len 7 clamps to 4 bytes
    vecs[3] = '{8'h3C, 4'd12, 64'h0807060504030201, 3'd7, 4, 32'hD4C3B2A1, -1, 9, 32'hD4C3B2A1, 2'b00};
    vecs[4] = '{8'h10, 4'd1, 64'hE7,                3'd1, 1, 32'h80,       -1, 2, 32'h00000080, 2'b00};
    vecs[5] = '{8'hFF, 4'd3, 64'hC35A96,            3'd3, 3, 32'h030201,   -1, 4, 32'h00030201, 2'b00};

    rst = 1'b0; req_valid = 1'b0; req_cmd = '0; req_payload = '0; req_len = '0;
    req_resp_len = '0; uart_rx = 1'b1; rsp_ready = 1'b0;
    tick();
    tick();
    check("reset_uart_tx", uart_tx, 1'b1);
    check("reset_req_ready", req_ready, 1'b0);
    check("reset_rsp", {rsp_valid, rsp_data, rsp_status}, 35'h0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b1;
    tick();
    check("ready_after_reset", req_ready, 1'b1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset during a payload frame, then a clean transaction.
    issue(8'h22, 4'd4, 64'h44332211, 3'd1);
    repeat (200) tick();
    n = 0;
    while (uart_tx !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    check("midframe_line_low", uart_tx, 1'b0);
    rst = 1'b0;
    #1;
    check("reset_abort_tx_immediate", uart_tx, 1'b1);
    tick();
    check("reset_abort_tx_first_cycle", uart_tx, 1'b1);
    check("reset_abort_state", {req_ready, busy, rsp_valid}, 3'b000);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("reset_abort_ready", req_ready, 1'b1);
    check("reset_abort_line_idle", uart_tx, 1'b1);
    run_vec(vecs[4], 40);

    // Response backpressure with ignored requests.
    issue(8'h05, 4'd0, 64'h0, 3'd1);
    repeat (170) tick();
    send_byte(8'h99, 1'b1);
    wait_rsp(200, ok);
    check("bp_rsp_valid", ok, 1'b1);
    snap = rsp_data;
    check("bp_rsp_data", snap, 32'h99);
    stable = 1'b1; tx_idle = 1'b1; rdy_low = 1'b1;
    for (int i = 0; i < 50; i++) begin
      req_valid = (i >= 10 && i < 14);
      req_cmd   = 8'h00;
      tick();
      stable  &= (rsp_valid === 1'b1) && (rsp_data === snap) && (rsp_status === 2'b00);
      tx_idle &= (uart_tx === 1'b1);
      rdy_low &= (req_ready === 1'b0);
    end
    req_valid = 1'b0;
    check("bp_rsp_stable", stable, 1'b1);
    check("bp_req_ignored_tx", tx_idle, 1'b1);
    check("bp_req_ready_low", rdy_low, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (5) tick();
    check("bp_back_to_idle", {rsp_valid, busy, uart_tx}, 3'b001);

    // One byte of a three-byte response.
    issue(8'h07, 4'd0, 64'h0, 3'd3);
    repeat (180) tick();
    ts = cyc;
    send_byte(8'h5A, 1'b1);
`ifdef TPU_UART_HOST_TIMEOUT_EN
    wait_rsp(400, ok);
    check("to_rsp_valid", ok, 1'b1);
    // 200 cycles counted from the confirmed start bit (~12 cycles after the line falls)
    check("to_delay_window", (cyc - ts >= 200 && cyc - ts <= 215), 1'b1);
    check("to_rsp_data", rsp_data, 32'h5A);
    check("to_rsp_status", rsp_status, 2'b01);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`else
    n = 0;
    ok = 1'b0;
    while (n < 600) begin
      tick();
      ok |= (rsp_valid === 1'b1);
      n++;
    end
    check("no_watchdog_waits", {ok, busy}, 2'b01);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
`endif
    check("final_idle", {req_ready, busy}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
